// File: rtl/video_timdet.sv
// Video timing detector: measures sync widths, gate delays and line/frame sizes, publishes per frame.
// Latency: results and meas_valid appear one clock after the vsync rising edge; no backpressure.
module video_timdet #(
    parameter int LOCK_CNT = 2,
    parameter int TO_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_ena,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        gate,
    output logic [7:0]  Thsync,
    output logic [7:0]  Thgdel,
    output logic [15:0] Thgate,
    output logic [15:0] Thlen,
    output logic [7:0]  Tvsync,
    output logic [7:0]  Tvgdel,
    output logic [15:0] Tvgate,
    output logic [15:0] Tvlen,
    output logic        meas_valid,
    output logic        locked,
    output logic        err
);

    localparam logic [3:0]  LOCK_TH = 4'(LOCK_CNT);
    localparam logic [31:0] TO_LIM  = 32'(TO_LIMIT);

    typedef enum logic {SEARCH = 1'b0, MEASURE = 1'b1} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] a, input logic b);
        return (b && a != 16'hFFFF) ? a + 16'd1 : a;
    endfunction

    function automatic logic [7:0] sat8(input logic [15:0] a);
        return (a > 16'd255) ? 8'hFF : a[7:0];
    endfunction

    state_t      state_q, state_d;
    logic        hs_p_q, hs_p_d, vs_p_q, vs_p_d, gt_p_q, gt_p_d;
    // current line
    logic [15:0] hcnt_q, hcnt_d, hsc_q, hsc_d, gdel_q, gdel_d, gcnt_q, gcnt_d;
    logic        low_seen_q, low_seen_d, gseen_q, gseen_d, grose_q, grose_d, lovf_q, lovf_d;
    // current frame
    logic [15:0] fh_sync_q, fh_sync_d, fh_gdel_q, fh_gdel_d, fh_gate_q, fh_gate_d, fh_len_q, fh_len_d;
    logic [15:0] vlen_q, vlen_d, vsc_q, vsc_d, vlow_idx_q, vlow_idx_d, vgdel_q, vgdel_d, vgate_q, vgate_d;
    logic        vlow_seen_q, vlow_seen_d, fgated_q, fgated_d, ferr_q, ferr_d;
    logic [31:0] to_h_q, to_h_d, to_v_q, to_v_d;
    // published results and lock tracking
    logic [7:0]  thsync_q, thsync_d, thgdel_q, thgdel_d, tvsync_q, tvsync_d, tvgdel_q, tvgdel_d;
    logic [15:0] thgate_q, thgate_d, thlen_q, thlen_d, tvgate_q, tvgate_d, tvlen_q, tvlen_d;
    logic        mv_q, mv_d, locked_q, locked_d, err_q, err_d, pub_seen_q, pub_seen_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;

    logic        h_rise, v_rise, g_rise, ev_err, line_gated, timeout, same;
    logic [15:0] line_idx, vgdel_calc;
    logic [15:0] fh_sync_u, fh_gdel_u, fh_gate_u, fh_len_u, vgdel_u, vgate_u;
    logic        fgated_u, ferr_u;
    logic [7:0]  pub_thsync, pub_thgdel, pub_tvsync, pub_tvgdel;
    logic        pub_err;

    always_comb begin
        h_rise = hsync & ~hs_p_q;
        v_rise = vsync & ~vs_p_q;
        g_rise = gate & ~gt_p_q;
        hs_p_d = hsync;
        vs_p_d = vsync;
        gt_p_d = gate;

        hcnt_d     = sat_inc(hcnt_q, 1'b1);
        hsc_d      = sat_inc(hsc_q, hsync);
        gdel_d     = gdel_q;
        gcnt_d     = sat_inc(gcnt_q, gate);
        low_seen_d = low_seen_q | ~hsync;
        gseen_d    = gseen_q;
        grose_d    = grose_q | g_rise;
        lovf_d     = lovf_q | (hcnt_q == 16'hFFFF);
        // Gate delay runs from the first hsync-low cycle until gate is first seen high.
        if ((~hsync | low_seen_q) & ~gseen_q) begin
            if (gate) gseen_d = 1'b1;
            else      gdel_d  = sat_inc(gdel_q, 1'b1);
        end
        if (h_rise) begin
            hcnt_d     = 16'd1;
            hsc_d      = 16'd1;
            gdel_d     = '0;
            gcnt_d     = {15'd0, gate};
            low_seen_d = 1'b0;
            gseen_d    = 1'b0;
            grose_d    = g_rise;
            lovf_d     = 1'b0;
        end
        ev_err = g_rise & (hsync | (grose_q & ~h_rise));

        // The line ending on this hsync edge still belongs to the frame being closed.
        line_gated = h_rise & (gcnt_q != 16'd0);
        line_idx   = vlen_q - 16'd1;
        vgdel_calc = (vlow_seen_q && vlen_q != 16'd0 && line_idx >= vlow_idx_q) ? line_idx - vlow_idx_q : '0;
        fh_sync_u  = line_gated ? hsc_q  : fh_sync_q;
        fh_gdel_u  = line_gated ? gdel_q : fh_gdel_q;
        fh_gate_u  = line_gated ? gcnt_q : fh_gate_q;
        fh_len_u   = line_gated ? hcnt_q : fh_len_q;
        vgdel_u    = (line_gated & ~fgated_q) ? vgdel_calc : vgdel_q;
        fgated_u   = fgated_q | line_gated;
        vgate_u    = sat_inc(vgate_q, line_gated);
        ferr_u     = ferr_q | (line_gated & fgated_q & (gcnt_q != fh_gate_q)) | (h_rise & lovf_q)
                   | (line_gated & (vgate_q == 16'hFFFF));

        pub_thsync = sat8(fh_sync_u);
        pub_thgdel = sat8(fh_gdel_u);
        pub_tvsync = sat8(vsc_q);
        pub_tvgdel = sat8(vgdel_u);
        pub_err    = ferr_u | (fh_sync_u > 16'd255) | (fh_gdel_u > 16'd255)
                   | (vsc_q > 16'd255) | (vgdel_u > 16'd255);

        if (v_rise) begin
            fh_sync_d   = '0;
            fh_gdel_d   = '0;
            fh_gate_d   = '0;
            fh_len_d    = '0;
            vgdel_d     = '0;
            vgate_d     = '0;
            fgated_d    = 1'b0;
            vlen_d      = {15'd0, h_rise};
            vsc_d       = {15'd0, h_rise & vsync};
            vlow_seen_d = 1'b0;
            vlow_idx_d  = '0;
            ferr_d      = ev_err;
        end else begin
            fh_sync_d   = fh_sync_u;
            fh_gdel_d   = fh_gdel_u;
            fh_gate_d   = fh_gate_u;
            fh_len_d    = fh_len_u;
            vgdel_d     = vgdel_u;
            vgate_d     = vgate_u;
            fgated_d    = fgated_u;
            vlen_d      = sat_inc(vlen_q, h_rise);
            vsc_d       = sat_inc(vsc_q, h_rise & vsync);
            vlow_seen_d = vlow_seen_q | (h_rise & ~vsync);
            vlow_idx_d  = (h_rise & ~vsync & ~vlow_seen_q) ? vlen_q : vlow_idx_q;
            ferr_d      = ferr_u | ev_err | (h_rise & (vlen_q == 16'hFFFF));
        end

        to_h_d  = h_rise ? '0 : ((to_h_q == '1) ? to_h_q : to_h_q + 32'd1);
        to_v_d  = v_rise ? '0 : ((h_rise && to_v_q != '1) ? to_v_q + 32'd1 : to_v_q);
        timeout = (~h_rise & (to_h_q >= TO_LIM)) | (h_rise & ~v_rise & (to_v_q >= TO_LIM));

        same = {pub_thsync, pub_thgdel, fh_gate_u, fh_len_u, pub_tvsync, pub_tvgdel, vgate_u, vlen_q}
            == {thsync_q, thgdel_q, thgate_q, thlen_q, tvsync_q, tvgdel_q, tvgate_q, tvlen_q};

        state_d    = state_q;
        thsync_d   = thsync_q;
        thgdel_d   = thgdel_q;
        thgate_d   = thgate_q;
        thlen_d    = thlen_q;
        tvsync_d   = tvsync_q;
        tvgdel_d   = tvgdel_q;
        tvgate_d   = tvgate_q;
        tvlen_d    = tvlen_q;
        err_d      = err_q;
        mv_d       = 1'b0;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        pub_seen_d = pub_seen_q;
        if (timeout) begin
            state_d    = SEARCH;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            pub_seen_d = 1'b0;
        end else if (v_rise) begin
            if (state_q == SEARCH) begin
                state_d = MEASURE;
            end else begin
                thsync_d   = pub_thsync;
                thgdel_d   = pub_thgdel;
                thgate_d   = fh_gate_u;
                thlen_d    = fh_len_u;
                tvsync_d   = pub_tvsync;
                tvgdel_d   = pub_tvgdel;
                tvgate_d   = vgate_u;
                tvlen_d    = vlen_q;
                err_d      = pub_err;
                mv_d       = 1'b1;
                pub_seen_d = 1'b1;
                if (pub_err)                     lock_cnt_d = '0;
                else if (!pub_seen_q || !same)   lock_cnt_d = 4'd1;
                else if (lock_cnt_q != 4'hF)     lock_cnt_d = lock_cnt_q + 4'd1;
                locked_d = (lock_cnt_d >= LOCK_TH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            {hs_p_q, vs_p_q, gt_p_q} <= '0;
            {hcnt_q, hsc_q, gdel_q, gcnt_q} <= '0;
            {low_seen_q, gseen_q, grose_q, lovf_q} <= '0;
            {fh_sync_q, fh_gdel_q, fh_gate_q, fh_len_q} <= '0;
            {vlen_q, vsc_q, vlow_idx_q, vgdel_q, vgate_q} <= '0;
            {vlow_seen_q, fgated_q, ferr_q} <= '0;
            {to_h_q, to_v_q} <= '0;
            {thsync_q, thgdel_q, tvsync_q, tvgdel_q} <= '0;
            {thgate_q, thlen_q, tvgate_q, tvlen_q} <= '0;
            {mv_q, locked_q, err_q, pub_seen_q} <= '0;
            lock_cnt_q <= '0;
        end else begin
            mv_q <= clk_ena & mv_d;
            if (clk_ena) begin
                state_q     <= state_d;
                hs_p_q      <= hs_p_d;
                vs_p_q      <= vs_p_d;
                gt_p_q      <= gt_p_d;
                hcnt_q      <= hcnt_d;
                hsc_q       <= hsc_d;
                gdel_q      <= gdel_d;
                gcnt_q      <= gcnt_d;
                low_seen_q  <= low_seen_d;
                gseen_q     <= gseen_d;
                grose_q     <= grose_d;
                lovf_q      <= lovf_d;
                fh_sync_q   <= fh_sync_d;
                fh_gdel_q   <= fh_gdel_d;
                fh_gate_q   <= fh_gate_d;
                fh_len_q    <= fh_len_d;
                vlen_q      <= vlen_d;
                vsc_q       <= vsc_d;
                vlow_idx_q  <= vlow_idx_d;
                vgdel_q     <= vgdel_d;
                vgate_q     <= vgate_d;
                vlow_seen_q <= vlow_seen_d;
                fgated_q    <= fgated_d;
                ferr_q      <= ferr_d;
                to_h_q      <= to_h_d;
                to_v_q      <= to_v_d;
                thsync_q    <= thsync_d;
                thgdel_q    <= thgdel_d;
                thgate_q    <= thgate_d;
                thlen_q     <= thlen_d;
                tvsync_q    <= tvsync_d;
                tvgdel_q    <= tvgdel_d;
                tvgate_q    <= tvgate_d;
                tvlen_q     <= tvlen_d;
                locked_q    <= locked_d;
                err_q       <= err_d;
                pub_seen_q  <= pub_seen_d;
                lock_cnt_q  <= lock_cnt_d;
            end
        end
    end

    assign Thsync     = thsync_q;
    assign Thgdel     = thgdel_q;
    assign Thgate     = thgate_q;
    assign Thlen      = thlen_q;
    assign Tvsync     = tvsync_q;
    assign Tvgdel     = tvgdel_q;
    assign Tvgate     = tvgate_q;
    assign Tvlen      = tvlen_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule

// File: tb/tb_video_timdet.sv
// Directed bench for video_timdet: 40-pixel lines, 20-line frames, lock/err/timeout/reset scenarios.
module tb_video_timdet;

    logic        clk = 1'b0;
    logic        rst, clk_ena, hsync, vsync, gate;
    logic [7:0]  Thsync, Thgdel, Tvsync, Tvgdel;
    logic [15:0] Thgate, Thlen, Tvgate, Tvlen;
    logic        meas_valid, locked, err;

    always #5 clk = ~clk;

    video_timdet #(.LOCK_CNT(2), .TO_LIMIT(200)) dut (
        .clk(clk), .rst(rst), .clk_ena(clk_ena),
        .hsync(hsync), .vsync(vsync), .gate(gate),
        .Thsync(Thsync), .Thgdel(Thgdel), .Thgate(Thgate), .Thlen(Thlen),
        .Tvsync(Tvsync), .Tvgdel(Tvgdel), .Tvgate(Tvgate), .Tvlen(Tvlen),
        .meas_valid(meas_valid), .locked(locked), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Publish monitor
    int   cyc = 0;
    int   pub_cnt = 0, mv_hi = 0, pub_cyc = 0, pub_gap = 0, pub_lat = -1, vedge_cyc = 0;
    logic mv_prev = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            mv_hi = mv_hi + 1;
            if (!mv_prev) begin
                pub_cnt = pub_cnt + 1;
                pub_gap = cyc - pub_cyc;
                pub_cyc = cyc;
                pub_lat = cyc - vedge_cyc;
            end
        end
        mv_prev = (meas_valid === 1'b1);
    end

    logic ena_mode = 1'b0;
    logic v_prev = 1'b0;

    task automatic step(input logic h, input logic v, input logic g);
        logic vr;
        vr = v & ~v_prev;
        hsync = h; vsync = v; gate = g; clk_ena = 1'b1;
        @(posedge clk); #1;
        if (vr) vedge_cyc = cyc;
        if (ena_mode) begin
            clk_ena = 1'b0;
            @(posedge clk); #1;
        end
        v_prev = v;
    endtask

    // 40-pixel lines: hsync 4, gate delay 6, gate 24; vsync on lines 0-1, gate on lines 5-14.
    task automatic send_frame(input int nlines, input int dbl, input int nsend);
        for (int l = 0; l < nsend; l++) begin
            for (int c = 0; c < 40; c++) begin
                logic g;
                g = (l >= 5 && l < 15 && c >= 10 && c < 34 && !(l == dbl && c == 20));
                step(c < 4, l < 2, g);
            end
        end
        if (nlines < nsend) $display("bad frame request");
    endtask

    task automatic chk_fmt(input string pfx, input int vlen);
        chk({pfx, "_thsync"}, 32'(Thsync), 4);
        chk({pfx, "_thgdel"}, 32'(Thgdel), 6);
        chk({pfx, "_thgate"}, 32'(Thgate), 24);
        chk({pfx, "_thlen"},  32'(Thlen),  40);
        chk({pfx, "_tvsync"}, 32'(Tvsync), 2);
        chk({pfx, "_tvgdel"}, 32'(Tvgdel), 3);
        chk({pfx, "_tvgate"}, 32'(Tvgate), 10);
        chk({pfx, "_tvlen"},  32'(Tvlen),  32'(vlen));
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_hvals"}, {Thsync, Thgdel, Tvsync, Tvgdel}, 0);
        chk({pfx, "_thgate"}, 32'(Thgate), 0);
        chk({pfx, "_thlen"},  32'(Thlen),  0);
        chk({pfx, "_tvgate"}, 32'(Tvgate), 0);
        chk({pfx, "_tvlen"},  32'(Tvlen),  0);
        chk({pfx, "_flags"}, {29'd0, meas_valid, locked, err}, 0);
    endtask

    initial begin
        rst = 1'b1; clk_ena = 1'b0; hsync = 1'b0; vsync = 1'b0; gate = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Basic measurement and lock
        send_frame(20, -1, 20); chk("f0_pubs", pub_cnt, 0);
        send_frame(20, -1, 20); chk("f1_pubs", pub_cnt, 1);
        chk_fmt("f1", 20);
        chk("f1_err", err, 0); chk("f1_locked", locked, 0); chk("f1_lat", pub_lat, 0);
        send_frame(20, -1, 20); chk("f2_pubs", pub_cnt, 2);
        chk("f2_locked", locked, 1); chk("f2_gap", pub_gap, 800);

        // One longer frame breaks lock without error
        send_frame(21, -1, 21); chk("f3_pubs", pub_cnt, 3); chk("f3_locked", locked, 1);
        send_frame(20, -1, 20); chk("f4_pubs", pub_cnt, 4);
        chk("f4_tvlen", Tvlen, 21); chk("f4_err", err, 0); chk("f4_locked", locked, 0);
        send_frame(20, -1, 20); chk("f5_tvlen", Tvlen, 20); chk("f5_locked", locked, 0);
        send_frame(20, -1, 20); chk("f6_locked", locked, 1);

        // Double gate pulse in line 7
        send_frame(20, 7, 20); chk("f7_locked", locked, 1); chk("f7_err", err, 0);
        send_frame(20, -1, 20); chk("f8_pubs", pub_cnt, 8);
        chk("f8_err", err, 1); chk("f8_locked", locked, 0); chk("f8_thgate", Thgate, 24);
        send_frame(20, -1, 20); chk("f9_err", err, 0); chk("f9_locked", locked, 0);
        send_frame(20, -1, 20); chk("f10_locked", locked, 1); chk("f10_pubs", pub_cnt, 10);

        // hsync stuck low beyond the timeout
        repeat (300) step(1'b0, 1'b0, 1'b0);
        chk("to_locked", locked, 0); chk("to_pubs", pub_cnt, 10); chk("to_err", err, 0);
        chk_fmt("to", 20);
        send_frame(20, -1, 20); chk("f11_pubs", pub_cnt, 10);
        send_frame(20, -1, 20); chk("f12_pubs", pub_cnt, 11); chk("f12_locked", locked, 0);
        chk_fmt("f12", 20);
        send_frame(20, -1, 20); chk("f13_locked", locked, 1);

        // Reset mid-frame with clk_ena low
        send_frame(20, -1, 10); chk("f14_pubs", pub_cnt, 13); chk("f14_locked", locked, 1);
        rst = 1'b1; clk_ena = 1'b0; hsync = 1'b0; vsync = 1'b0; gate = 1'b0;
        @(posedge clk); #1;
        chk_zero("midrst");
        rst = 1'b0; v_prev = 1'b0;
        send_frame(20, -1, 20); chk("f15_pubs", pub_cnt, 13);
        send_frame(20, -1, 20); chk("f16_pubs", pub_cnt, 14); chk("f16_locked", locked, 0);
        chk_fmt("f16", 20); chk("f16_lat", pub_lat, 0);

        // Clock enable toggled every cycle
        ena_mode = 1'b1;
        send_frame(20, -1, 20); chk("f17_gap", pub_gap, 800); chk("f17_locked", locked, 1);
        send_frame(20, -1, 20); chk("f18_pubs", pub_cnt, 16); chk("f18_gap", pub_gap, 1600);
        chk_fmt("f18", 20); chk("f18_lat", pub_lat, 0); chk("f18_err", err, 0);
        send_frame(20, -1, 20); chk("f19_gap", pub_gap, 1600); chk("f19_locked", locked, 1);
        chk("mv_width", mv_hi, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_timdet.md
VIDEO_TIMDET -- requirements
Module: video_timdet

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 2: consecutive identical error-free measurement sets required to assert locked (range 1..15).
REQ-002 SHALL have parameter TO_LIMIT, default 65535: enabled cycles without an hsync rising edge, or lines without a vsync rising edge, before timeout.
REQ-003 SHALL have port clk  in  1  master clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port clk_ena  in  1  clock enable; sampling, counting and state changes occur only when high.
REQ-006 SHALL have ports hsync, vsync, gate  in  1 each  incoming active-high sync pulses and visible-pixel gate, synchronous to clk.
REQ-007 SHALL have ports Thsync, Thgdel  out  8 each  measured hsync width and horizontal gate delay, in pixels.
REQ-008 SHALL have ports Thgate, Thlen  out  16 each  measured visible pixels per line and total pixels per line.
REQ-009 SHALL have ports Tvsync, Tvgdel  out  8 each; Tvgate, Tvlen  out  16 each  vertical equivalents, in lines.
REQ-010 SHALL have port meas_valid  out  1  one-cycle pulse when a new measurement set is published.
REQ-011 SHALL have port locked  out  1  level: stable format detected.
REQ-012 SHALL have port err  out  1  published set contains a format error.

Function
REQ-013 SHALL register hsync/vsync/gate once; edges = current sample vs. previous enabled sample.
REQ-014 SHALL report raw counts, with no offset encoding.
REQ-015 Thlen SHALL = enabled cycles from one hsync rising edge (inclusive) to the next (exclusive).
REQ-016 Thsync SHALL = enabled cycles hsync high, starting at the rising edge.
REQ-017 Thgdel SHALL = enabled cycles from the first hsync-low cycle to the first gate-high cycle of that line; 0 if gate rises on that first low cycle.
REQ-018 Thgate SHALL = gate-high cycles in the line.
REQ-019 Published horizontal values SHALL come from the last line of the frame containing gate.
REQ-020 A line SHALL begin at an hsync rising edge; a frame SHALL begin at a vsync rising edge.
REQ-021 An hsync edge coincident with a vsync edge SHALL count as line 0 of the new frame.
REQ-022 Tvlen SHALL = hsync rising edges in the frame.
REQ-023 Tvsync SHALL = hsync rising edges while vsync is high.
REQ-024 Tvgdel SHALL = lines from the first line starting with vsync low to the first line containing gate.
REQ-025 Tvgate SHALL = lines containing at least one gate-high cycle.
REQ-026 FSM SHALL have states SEARCH and MEASURE; reset enters SEARCH.
REQ-027 SEARCH -> MEASURE SHALL occur on the first vsync rising edge; no publish occurs on that edge.
REQ-028 In MEASURE, each vsync rising edge SHALL publish the completed frame.
REQ-029 Publish: outputs and err update, and meas_valid pulses, on the clock after the edge; new-frame counters restart on the same edge.
REQ-030 err SHALL be set in a frame on any of:
  - a second gate rising edge within one line;
  - gate rising while hsync is high;
  - Thgate differing between gated lines;
  - any count exceeding its output width.
REQ-031 Counts exceeding output width SHALL saturate (255 / 65535).
REQ-032 Timeout (TO_LIMIT exceeded) SHALL:
  - return the FSM to SEARCH;
  - clear locked;
  - hold published outputs;
  - not pulse meas_valid.
REQ-033 Lock counter SHALL:
  - increment on a publish equal to the previous publish with err=0 (first publish after SEARCH counts 1);
  - reset to 1 on mismatch, or to 0 if err=1.
REQ-034 locked SHALL be high iff lock counter >= LOCK_CNT; it updates with meas_valid.
REQ-035 With clk_ena low, all state and outputs SHALL hold; meas_valid SHALL not assert.

Reset
REQ-036 rst high at a clock edge SHALL zero all outputs and counters, enter SEARCH, and clear the edge-detect history, regardless of clk_ena.
REQ-037 Reset mid-frame SHALL discard partial measurements; the first publish after release requires two vsync rising edges.

Verification
REQ-038 Stimulus Thsync=4, Thgdel=6, Thgate=24, Thlen=40, Tvsync=2, Tvgdel=3, Tvgate=10, Tvlen=20, clk_ena=1 -> first meas_valid after the 2nd vsync edge with exactly those values, err=0; locked=1 at the 2nd publish.
REQ-039 clk_ena toggled 1/0 on the same stream -> identical values; publish timing stretched 2x.
REQ-040 Locked stream, then one frame with Tvlen=21 -> err=0, locked=0 at that publish, locked=1 again after the next identical frame.
REQ-041 Line with two gate pulses -> err=1 and locked=0 at the publish; next clean frame gives err=0.
REQ-042 hsync held low for TO_LIMIT+1 cycles while locked -> locked=0, state SEARCH, outputs unchanged, no meas_valid.
REQ-043 rst asserted mid-frame while locked -> next cycle all outputs 0; first meas_valid after the 2nd subsequent vsync edge.
